// File: rtl/axi_periph_bridge_if.sv
// axi_periph_bridge_if: AXI4-Lite slave side and APB-style peripheral side of
// the peripheral bridge, plus the sticky error flag and its clear.
// slave modport = bridge view, master modport = fabric/peripheral view.
interface axi_periph_bridge_if #(
   parameter int unsigned NUM_PERIPH = 4,
   parameter int unsigned SLOT_SHIFT = 12
);
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   // AXI4-Lite write channels
   logic [ADDR_W-1:0]            awaddr;
   logic                         awvalid;
   logic                         awready;
   logic [DATA_W-1:0]            wdata;
   logic [STRB_W-1:0]            wstrb;
   logic                         wvalid;
   logic                         wready;
   logic                         bvalid;
   logic                         bready;
   // AXI4-Lite read channels
   logic [ADDR_W-1:0]            araddr;
   logic                         arvalid;
   logic                         arready;
   logic [DATA_W-1:0]            rdata;
   logic                         rvalid;
   logic                         rready;
   // peripheral bus
   logic [NUM_PERIPH-1:0]        psel;
   logic                         penable;
   logic                         pwrite;
   logic [SLOT_SHIFT-1:0]        paddr;
   logic [DATA_W-1:0]            pwdata;
   logic [STRB_W-1:0]            pstrb;
   logic [NUM_PERIPH*DATA_W-1:0] prdata;
   logic [NUM_PERIPH-1:0]        pready;
   logic [NUM_PERIPH-1:0]        pslverr;
   // error flag
   logic                         bus_err;
   logic                         bus_err_clr;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arvalid, rready,
      input  prdata, pready, pslverr, bus_err_clr,
      output awready, wready, bvalid, arready, rdata, rvalid,
      output psel, penable, pwrite, paddr, pwdata, pstrb, bus_err
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arvalid, rready,
      output prdata, pready, pslverr, bus_err_clr,
      input  awready, wready, bvalid, arready, rdata, rvalid,
      input  psel, penable, pwrite, paddr, pwdata, pstrb, bus_err
   );
endinterface

// File: rtl/axi_periph_bridge.sv
// axi_periph_bridge: single-beat AXI4-Lite slave to APB-style SETUP/ACCESS
// peripheral bus with one-hot slot decode and a sticky error flag.
// Optional ACCESS-phase timeout: define PBRIDGE_TIMEOUT_EN.
module axi_periph_bridge #(
   parameter int unsigned NUM_PERIPH     = 4,
   parameter int unsigned SLOT_SHIFT     = 12,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                clk,
   input logic                rst_n,
   axi_periph_bridge_if.slave bus
);
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned SLOT_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_WRESP,
      S_RRESP
   } state_e;

   state_e                state_q, state_d;
   logic                  awready_q, awready_d;
   logic                  arready_q, arready_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic                  wr_q, wr_d;
   logic [NUM_PERIPH-1:0] psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [SLOT_SHIFT-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0]     pwdata_q, pwdata_d;
   logic [STRB_W-1:0]     pstrb_q, pstrb_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;
   logic                  bvalid_q, bvalid_d;
   logic                  rvalid_q, rvalid_d;
   logic                  bus_err_q, bus_err_d;
   logic                  err_set;
   logic                  in_xfer;

   logic [DATA_W-1:0]     acc_rdata;
   logic                  acc_ready;
   logic                  acc_err;
   logic [SLOT_W-1:0]     aw_slot;
   logic [SLOT_W-1:0]     ar_slot;
   logic                  wr_req;

`ifdef PBRIDGE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]      cnt_q, cnt_d;
`else
   logic                  unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

   // address bits above the slot index are decoded upstream by the fabric
   logic unused_addr;
   assign unused_addr = ^{bus.awaddr[ADDR_W-1:SLOT_SHIFT+SLOT_W],
                          bus.araddr[ADDR_W-1:SLOT_SHIFT+SLOT_W]};

   assign aw_slot = bus.awaddr[SLOT_SHIFT+SLOT_W-1 -: SLOT_W];
   assign ar_slot = bus.araddr[SLOT_SHIFT+SLOT_W-1 -: SLOT_W];
   assign wr_req  = bus.awvalid && bus.wvalid;

   function automatic logic is_mapped(input logic [SLOT_W-1:0] s);
      return 32'(s) < NUM_PERIPH;
   endfunction

   // select the addressed slot's ready/error/data
   always_comb begin
      acc_rdata = '0;
      acc_ready = 1'b0;
      acc_err   = 1'b0;
      for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
         if (slot_q == SLOT_W'(k)) begin
            acc_rdata = bus.prdata[DATA_W*k +: DATA_W];
            acc_ready = bus.pready[k];
            acc_err   = bus.pslverr[k];
         end
      end
   end

   // next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      wr_d     = wr_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      rdata_d  = rdata_q;
      err_set  = 1'b0;
`ifdef PBRIDGE_TIMEOUT_EN
      cnt_d    = cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            // the ready pulse raised last cycle completes the handshake now
            if (awready_q) begin
               slot_d = aw_slot;
               wr_d   = 1'b1;
               if (is_mapped(aw_slot)) begin
                  paddr_d  = bus.awaddr[SLOT_SHIFT-1:0];
                  pwrite_d = 1'b1;
                  pwdata_d = bus.wdata;
                  pstrb_d  = bus.wstrb;
                  state_d  = S_SETUP;
               end else begin
                  err_set = 1'b1;
                  rdata_d = '0;
                  state_d = S_WRESP;
               end
            end else if (arready_q) begin
               slot_d = ar_slot;
               wr_d   = 1'b0;
               if (is_mapped(ar_slot)) begin
                  paddr_d  = bus.araddr[SLOT_SHIFT-1:0];
                  pwrite_d = 1'b0;
                  pwdata_d = '0;
                  pstrb_d  = '0;
                  state_d  = S_SETUP;
               end else begin
                  err_set = 1'b1;
                  rdata_d = '0;
                  state_d = S_RRESP;
               end
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
`ifdef PBRIDGE_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_ACCESS: begin
            if (acc_ready) begin
               if (acc_err) begin
                  err_set = 1'b1;
                  rdata_d = '0;
               end else if (!wr_q) begin
                  rdata_d = acc_rdata;
               end
               state_d = wr_q ? S_WRESP : S_RRESP;
            end
`ifdef PBRIDGE_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               err_set = 1'b1;
               rdata_d = '0;
               state_d = wr_q ? S_WRESP : S_RRESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_WRESP: if (bus.bready) state_d = S_IDLE;
         S_RRESP: if (bus.rready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // peripheral strobes are only live during SETUP/ACCESS; paddr holds
      in_xfer = (state_d == S_SETUP) || (state_d == S_ACCESS);
      if (!in_xfer) begin
         pwrite_d = 1'b0;
         pwdata_d = '0;
         pstrb_d  = '0;
      end
      for (int unsigned k = 0; k < NUM_PERIPH; k++) begin
         psel_d[k] = in_xfer && (slot_d == SLOT_W'(k));
      end
      penable_d = (state_d == S_ACCESS);
      bvalid_d  = (state_d == S_WRESP);
      rvalid_d  = (state_d == S_RRESP);

      // single-cycle accept pulses, write wins over read
      awready_d = (state_d == S_IDLE) && wr_req;
      arready_d = (state_d == S_IDLE) && !wr_req && bus.arvalid;

      // set beats clear when both happen together
      bus_err_d = err_set ? 1'b1 : (bus.bus_err_clr ? 1'b0 : bus_err_q);
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         slot_q    <= '0;
         wr_q      <= 1'b0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         rdata_q   <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         bus_err_q <= 1'b0;
`ifdef PBRIDGE_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         awready_q <= awready_d;
         arready_q <= arready_d;
         slot_q    <= slot_d;
         wr_q      <= wr_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         rdata_q   <= rdata_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         bus_err_q <= bus_err_d;
`ifdef PBRIDGE_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign bus.awready = awready_q;
   assign bus.wready  = awready_q;
   assign bus.arready = arready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.psel    = psel_q;
   assign bus.penable = penable_q;
   assign bus.pwrite  = pwrite_q;
   assign bus.paddr   = paddr_q;
   assign bus.pwdata  = pwdata_q;
   assign bus.pstrb   = pstrb_q;
   assign bus.bus_err = bus_err_q;
endmodule

// File: doc/axi_periph_bridge.md
# axi_periph_bridge

- AXI4-Lite slave to APB-style peripheral bus bridge.
- Sits directly downstream of the bus fabric's peripheral slave port, which covers 0x2000_0000–0x2FFF_FFFF.
- Converts each single-beat read or write into a two-phase SETUP/ACCESS transfer.
- Decodes a one-hot peripheral select from the address and returns data or completion to the fabric.

## Interface
Parameters:
- NUM_PERIPH, 4: number of peripheral slots; one psel bit each.
- SLOT_SHIFT, 12: log2 of slot size; slot index = addr[SLOT_SHIFT+3:SLOT_SHIFT].
- TIMEOUT_CYCLES, 255: ACCESS-phase cycle limit (only with PBRIDGE_TIMEOUT_EN).

Ports (clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address accept
- wdata  in  32  write data
- wstrb  in  4  write byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data accept
- bvalid  out  1  write response valid
- bready  in  1  write response accept
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address accept
- rdata  out  32  read data
- rvalid  out  1  read data valid
- rready  in  1  read data accept
- psel  out  NUM_PERIPH  one-hot peripheral select
- penable  out  1  ACCESS phase
- pwrite  out  1  1 = write
- paddr  out  SLOT_SHIFT  byte offset within slot
- pwdata  out  32  write data
- pstrb  out  4  write strobes
- prdata  in  NUM_PERIPH*32  per-slot read data; slot k occupies bits [32k+31:32k]
- pready  in  NUM_PERIPH  per-slot ready
- pslverr  in  NUM_PERIPH  per-slot error
- bus_err  out  1  sticky error flag
- bus_err_clr  in  1  clears bus_err

## Operation
FSM states: IDLE, SETUP, ACCESS, WRESP, RRESP.

IDLE:
- If awvalid and wvalid are both high: assert awready and wready together for one cycle. Latch addr, data, strb, and direction = write.
- Else if arvalid: assert arready for one cycle and latch addr.
- Write wins when a write and a read are both pending.
- Slot decoding from the latched address:
  - Slot index < NUM_PERIPH: go to SETUP.
  - Slot index >= NUM_PERIPH (unmapped): go directly to WRESP or RRESP with rdata = 0, set bus_err, and drive no psel.

SETUP:
- psel[slot] = 1, penable = 0.
- paddr, pwrite, pwdata, pstrb are driven from the latched values.
- Always lasts exactly one cycle, then go to ACCESS.

ACCESS:
- psel[slot] = 1, penable = 1.
- Stay while pready[slot] = 0.
- On pready[slot] = 1:
  - Register prdata[slot] into rdata (reads only).
  - If pslverr[slot] = 1: set bus_err, and force rdata to 0.
  - Go to WRESP or RRESP.

WRESP / RRESP:
- bvalid (or rvalid) stays high until bready (or rready) is sampled high, then return to IDLE.
- rdata is stable while rvalid is high.

Outputs between transfers:
- psel, penable, pwrite, pwdata, pstrb are all 0 in IDLE, WRESP and RRESP.
- paddr holds its last value.

bus_err:
- Set takes priority over bus_err_clr in the same cycle.

Reset:
- All outputs are 0; FSM is in IDLE; latched registers are 0.
- Reset asserted mid-transfer abandons the transfer immediately and drops psel/penable asynchronously.

## Timing
- Mapped write with zero wait states:
  - cycle 0: awready/wready
  - cycle 1: SETUP
  - cycle 2: ACCESS with pready = 1
  - cycle 3: bvalid
- Each cycle pready is held low adds exactly one ACCESS cycle.
- Unmapped access: accept at cycle 0, bvalid/rvalid at cycle 1.
- Back-to-back: the next accept can occur in the cycle after the response handshake. Minimum transfer period is 4 cycles for mapped access.
- awready, wready, arready are single-cycle pulses, asserted only in IDLE.
- Every valid response stays high until its ready is sampled high.

## Configuration
- PBRIDGE_TIMEOUT_EN defined:
  - A counter is cleared on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES with pready still low: abort the transfer (psel/penable low next cycle), set bus_err, return rdata = 0, and complete via WRESP/RRESP.
- PBRIDGE_TIMEOUT_EN undefined: no counter; ACCESS waits for pready indefinitely.

## Test plan
- Write 0xCAFE_F00D, strb 0xF, to 0x2000_1008; slot 1 pready = 1 → psel = 0b0010, paddr = 0x008, pwrite = 1, penable at cycle 2, bvalid at cycle 3, bus_err = 0.
- Read 0x2000_2010; slot 2 holds pready low for 3 cycles, then returns 0x1234_5678 → rvalid at cycle 6 with rdata = 0x1234_5678; rvalid held while rready is low for 2 cycles.
- Read 0x2000_7000 (slot 7, unmapped) → no psel, rvalid at cycle 1, rdata = 0, bus_err = 1; pulse bus_err_clr → bus_err = 0.
- awvalid, wvalid and arvalid asserted in the same cycle → write is accepted first and arready stays 0; the read is accepted in the cycle after bready.
- Slot 0 responds with pslverr = 1 on a read → rdata = 0, bus_err = 1. Separately, with PBRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES = 8 and pready held at 0 → abort after 8 ACCESS cycles, rvalid with rdata = 0.
- rst_n asserted during ACCESS → psel and penable are 0 immediately; after release, a new read completes normally.
